// File: rtl/hamming_decoder_pkg.sv
// Shared definitions for the SECDED byte-stream decoder: status codes,
// FSM state encoding, codeword bit positions and a data-extraction helper.
package hamming_decoder_pkg;

  typedef enum logic [1:0] {
    CLEAN = 2'b00,
    SEC   = 2'b01,
    DED   = 2'b10
  } dec_stat_t;

  typedef enum logic [2:0] {
    RX_LO = 3'd0,
    RX_HI = 3'd1,
    CHECK = 3'd2,
    TX_LO = 3'd3,
    TX_HI = 3'd4
  } dec_state_t;

  // Parity bits sit at the power-of-two Hamming positions; p0 is overall parity.
  localparam int P0_POS = 0;
  localparam int P1_POS = 1;
  localparam int P2_POS = 2;
  localparam int P4_POS = 4;
  localparam int P8_POS = 8;

  // d1..d11 in order, as codeword bit indices.
  localparam int DATA_POS [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  // Gather the eleven data bits of a codeword into d11..d1 order.
  function automatic logic [10:0] extract_data(input logic [15:0] w);
    logic [10:0] d;
    d = '0;
    for (int i = 0; i < 11; i++) begin
      d[i] = w[DATA_POS[i]];
    end
    return d;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational SECDED check of one 16-bit codeword: syndrome, overall
// parity, single-bit-corrected word and the resulting status code.
module hamming_syndrome
  import hamming_decoder_pkg::*;
(
  input  logic [15:0] word,
  output logic [3:0]  s,
  output logic        p,
  output logic [15:0] corrected,
  output dec_stat_t   stat
);

  // Syndrome is the XOR of the positions of all set bits; odd overall parity
  // means exactly one flipped bit, located at s (s==0 points at p0 itself).
  always_comb begin
    s         = '0;
    p         = ^word;
    corrected = word;
    stat      = CLEAN;
    for (int i = 1; i < 16; i++) begin
      if (word[i]) s = s ^ 4'(i);
    end
    if (p) begin
      corrected[s] = ~word[s];
      stat         = SEC;
    end else if (s != 4'd0) begin
      stat = DED;
    end
  end

endmodule

// File: rtl/hamming_decoder.sv
// Sequential SECDED decoder on a valid/ready byte stream. Two codeword bytes
// in (LSW first), one check cycle, two result bytes out (LSW first).
//
// Handshake: a byte moves on a rising edge where valid and ready are both
// high. InReady depends only on state, OutValid/OutData only on registers,
// so there is no combinational path from the input side to the output side,
// and the output byte stays put while OutValid is high and OutReady is low.
module hamming_decoder
  import hamming_decoder_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [W-1:0]     InData,
  input  logic             InValid,
  output logic             InReady,
  output logic [W-1:0]     OutData,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [1:0]       Status,
  output logic [CNT_W-1:0] SingleCnt,
  output logic [CNT_W-1:0] DoubleCnt,
  input  logic             ClrCnt,
  output logic             Busy,
  output logic [2:0]       DbgState
);

  dec_state_t  state_q;
  dec_stat_t   status_q;
  logic [15:0] word_q;
  logic [W-1:0] lsw_q;
  logic [W-1:0] msw_q;

  logic [3:0]  syn_s;
  logic        syn_p;
  logic [15:0] syn_corr;
  dec_stat_t   syn_stat;
  logic [10:0] data_out;

  hamming_syndrome u_syndrome (
    .word      (word_q),
    .s         (syn_s),
    .p         (syn_p),
    .corrected (syn_corr),
    .stat      (syn_stat)
  );

  // A DED word is never flipped by the checker, so the corrected word is
  // also the raw word in that case and one extraction path serves all cases.
  assign data_out = extract_data(syn_corr);

  // Handshake and debug outputs are pure functions of registered state.
  assign InReady  = (state_q == RX_LO) || (state_q == RX_HI);
  assign OutValid = (state_q == TX_LO) || (state_q == TX_HI);
  assign OutData  = (state_q == TX_HI) ? msw_q : lsw_q;
  assign Busy     = (state_q != RX_LO);
  assign Status   = status_q;
  assign DbgState = state_q;

  // Main FSM: collect two bytes, check once, then present two result bytes.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q  <= RX_LO;
      status_q <= CLEAN;
      word_q   <= '0;
      lsw_q    <= '0;
      msw_q    <= '0;
    end else begin
      case (state_q)
        RX_LO: if (InValid) begin
          word_q[7:0] <= InData;
          state_q     <= RX_HI;
        end
        RX_HI: if (InValid) begin
          word_q[15:8] <= InData;
          state_q      <= CHECK;
        end
        CHECK: begin
          lsw_q    <= data_out[7:0];
          msw_q    <= {syn_stat, 3'b000, data_out[10:8]};
          status_q <= syn_stat;
          state_q  <= TX_LO;
        end
        TX_LO: if (OutReady) state_q <= TX_HI;
        TX_HI: if (OutReady) state_q <= RX_LO;
        default: state_q <= RX_LO;
      endcase
    end
  end

  // Saturating error counters; a clear beats a same-cycle increment.
  always_ff @(posedge Clk) begin
    if (!Reset || ClrCnt) begin
      SingleCnt <= '0;
      DoubleCnt <= '0;
    end else if (state_q == CHECK) begin
      if (syn_stat == SEC && SingleCnt != '1) SingleCnt <= SingleCnt + 1'b1;
      if (syn_stat == DED && DoubleCnt != '1) DoubleCnt <= DoubleCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hamming_decoder.sv
// Directed bench for hamming_decoder: codeword byte pairs with hand-computed
// result bytes, handshake stall/latency checks, reset and counter behaviour.
module tb_hamming_decoder;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] InData;
  logic       InValid;
  logic       InReady;
  logic [7:0] OutData;
  logic       OutValid;
  logic       OutReady;
  logic [1:0] Status;
  logic [7:0] SingleCnt;
  logic [7:0] DoubleCnt;
  logic       ClrCnt;
  logic       Busy;
  logic [2:0] DbgState;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  hamming_decoder #(.W(8), .CNT_W(8)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .InData    (InData),
    .InValid   (InValid),
    .InReady   (InReady),
    .OutData   (OutData),
    .OutValid  (OutValid),
    .OutReady  (OutReady),
    .Status    (Status),
    .SingleCnt (SingleCnt),
    .DoubleCnt (DoubleCnt),
    .ClrCnt    (ClrCnt),
    .Busy      (Busy),
    .DbgState  (DbgState)
  );

  // Clock
  always #5 Clk = ~Clk;

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one byte; returns just after the edge that consumed it.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge Clk);
    InData  = b;
    InValid = 1'b1;
    while (!InReady && n < 20) begin
      @(negedge Clk);
      n++;
    end
    if (!InReady) chk("in_ready_timeout", 16'(InReady), 16'd1);
    @(posedge Clk);
    #1;
    InValid = 1'b0;
  endtask

  // Accept one byte and compare it against the head of the expected queue.
  task automatic recv_byte(input string tag);
    int n;
    logic [7:0] e;
    n = 0;
    e = 8'h00;
    @(negedge Clk);
    OutReady = 1'b1;
    while (!OutValid && n < 20) begin
      @(negedge Clk);
      n++;
    end
    chk({tag, "_valid"}, 16'(OutValid), 16'd1);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    chk(tag, 16'(OutData), 16'(e));
    @(posedge Clk);
    #1;
    OutReady = 1'b0;
  endtask

  task automatic run_word(input string tag, input logic [7:0] lo, input logic [7:0] hi,
                          input logic [7:0] exp_lo, input logic [7:0] exp_hi,
                          input logic [1:0] exp_stat);
    exp_q.push_back(exp_lo);
    exp_q.push_back(exp_hi);
    send_byte(lo);
    send_byte(hi);
    recv_byte({tag, "_lsw"});
    recv_byte({tag, "_msw"});
    chk({tag, "_status"}, 16'(Status), 16'(exp_stat));
  endtask

  initial begin
    Reset    = 1'b0;
    InData   = 8'h00;
    InValid  = 1'b0;
    OutReady = 1'b0;
    ClrCnt   = 1'b0;

    // Reset state
    @(posedge Clk);
    @(negedge Clk);
    chk("rst_in_ready",  16'(InReady),   16'd1);
    chk("rst_out_valid", 16'(OutValid),  16'd0);
    chk("rst_status",    16'(Status),    16'd0);
    chk("rst_single",    16'(SingleCnt), 16'd0);
    chk("rst_double",    16'(DoubleCnt), 16'd0);
    chk("rst_busy",      16'(Busy),      16'd0);
    Reset = 1'b1;

    // 1: all-zero clean word, with latency check
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    @(negedge Clk);
    chk("t1_check_valid", 16'(OutValid), 16'd0);
    chk("t1_check_ready", 16'(InReady),  16'd0);
    chk("t1_check_busy",  16'(Busy),     16'd1);
    @(negedge Clk);
    chk("t1_tx_valid", 16'(OutValid), 16'd1);
    recv_byte("t1_lsw");
    recv_byte("t1_msw");
    chk("t1_status", 16'(Status),    16'd0);
    chk("t1_single", 16'(SingleCnt), 16'd0);
    chk("t1_double", 16'(DoubleCnt), 16'd0);

    // 2: all-ones clean word
    run_word("t2", 8'hFF, 8'hFF, 8'hFF, 8'h07, 2'b00);

    // 3: position 5 flipped -> corrected
    run_word("t3", 8'hDF, 8'hFF, 8'hFF, 8'h47, 2'b01);
    chk("t3_single", 16'(SingleCnt), 16'd1);

    // 4: positions 3 and 5 flipped -> uncorrectable
    run_word("t4", 8'hD7, 8'hFF, 8'hFC, 8'h87, 2'b10);
    chk("t4_double", 16'(DoubleCnt), 16'd1);
    chk("t4_single", 16'(SingleCnt), 16'd1);

    // 5: p0 flipped, consumer stalls for 5 cycles on the first byte
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h47);
    send_byte(8'hFE);
    send_byte(8'hFF);
    @(negedge Clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk("t5_stall_valid", 16'(OutValid), 16'd1);
      chk("t5_stall_data",  16'(OutData),  16'h00FF);
    end
    recv_byte("t5_lsw");
    recv_byte("t5_msw");
    chk("t5_status", 16'(Status),    16'd1);
    chk("t5_single", 16'(SingleCnt), 16'd2);
    chk("t5_double", 16'(DoubleCnt), 16'd1);

    // ClrCnt coincident with a single-error increment
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h47);
    send_byte(8'hDF);
    send_byte(8'hFF);
    ClrCnt = 1'b1;
    @(posedge Clk);
    #1;
    ClrCnt = 1'b0;
    recv_byte("clr_lsw");
    recv_byte("clr_msw");
    chk("clr_single", 16'(SingleCnt), 16'd0);
    chk("clr_double", 16'(DoubleCnt), 16'd0);
    chk("clr_status", 16'(Status),    16'd1);

    // 6: reset mid-word discards the partial LSW
    send_byte(8'h12);
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(negedge Clk);
    chk("t6_busy",     16'(Busy),    16'd0);
    chk("t6_in_ready", 16'(InReady), 16'd1);
    chk("t6_status",   16'(Status),  16'd0);
    run_word("t6", 8'hFF, 8'hFF, 8'hFF, 8'h07, 2'b00);

    // DoubleCnt saturation after 260 uncorrectable words
    for (int i = 0; i < 260; i++) begin
      run_word("sat", 8'hD7, 8'hFF, 8'hFC, 8'h87, 2'b10);
    end
    chk("sat_double", 16'(DoubleCnt), 16'd255);
    chk("sat_single", 16'(SingleCnt), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
